// File: rtl/hex_display_pkg.sv
// Shared defaults, constants and width helper for the hex display scanner.
package hex_display_pkg;

    localparam int DEF_NUM_DIGITS = 8;
    localparam int DEF_PRESCALE   = 50000;

    // Every digit enable deasserted (common-anode, active-low); sliced to NUM_DIGITS by users.
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    // Ceiling log2, used to size the prescaler and digit index.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..PRESCALE-1 and asserts a one-cycle tick on the last count.
module scan_tick_gen
    import hex_display_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int                CNT_W = clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tick = (r_count == LAST);

    // Free-running slot counter, wrapping on the tick cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a captured hex value across common-anode digits, one nibble per
// scan slot, with frame-aligned value updates and optional leading-zero blanking.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int PRESCALE   = DEF_PRESCALE
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_blank_lz,
    output logic [3:0]              o_nibble,
    output logic [NUM_DIGITS-1:0]   o_digit_an,
    output logic                    o_seg_blank,
    output logic                    o_frame_start
);

    localparam int                   VAL_W    = 4 * NUM_DIGITS;
    localparam int                   IDX_W    = clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = DIGIT_OFF[NUM_DIGITS-1:0];

    logic                  w_tick;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_idx_next;
    logic [VAL_W-1:0]      w_disp_next;
    logic [VAL_W-1:0]      w_shifted;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_an_lit;

    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_disp;
    logic [VAL_W-1:0]      r_pend;
    logic                  r_pend_valid;

    scan_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // Index the next slot will show; the wrap back to digit 0 marks a frame boundary.
    assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    assign w_wrap     = w_tick && (r_idx == LAST_IDX);

    // Display value as it will be after this cycle; a load on the wrap tick bypasses the pending copy.
    assign w_disp_next = !w_wrap     ? r_disp  :
                         i_load       ? i_value :
                         r_pend_valid ? r_pend  : r_disp;

    // Shifting the selected nibble down to bit 0 gives both the nibble and the
    // "everything from this digit upward is zero" test used for blanking.
    assign w_shifted = w_disp_next >> {w_idx_next, 2'b00};
    assign w_blank   = i_blank_lz && (w_idx_next != '0) && (w_shifted == '0);
    assign w_an_lit  = ~(NUM_DIGITS'(1) << w_idx_next);

    // Scan position advances once per slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= w_idx_next;
        end
    end

    // Loads land in a pending register and are promoted only at frame start, so a frame never tears.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_wrap) begin
            r_disp       <= w_disp_next;
            r_pend_valid <= 1'b0;
            if (i_load) begin
                r_pend <= i_value;
            end
        end else if (i_load) begin
            r_pend       <= i_value;
            r_pend_valid <= 1'b1;
        end
    end

    // Registered drive to the decoder and digit enables, refreshed once per slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_nibble      <= 4'h0;
            o_digit_an    <= AN_OFF;
            o_seg_blank   <= 1'b1;
            o_frame_start <= 1'b0;
        end else if (w_tick) begin
            o_nibble      <= w_shifted[3:0];
            o_digit_an    <= w_blank ? AN_OFF : w_an_lit;
            o_seg_blank   <= w_blank;
            o_frame_start <= (w_idx_next == '0);
        end else begin
            o_frame_start <= 1'b0;
        end
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Upstream feeder for the hex-to-7-segment decoder on the board display path. Captures a 32-bit value (CPU register/PC/ALU result) and time-multiplexes it across NUM_DIGITS common-anode digits. Each scan slot emits one 4-bit nibble to the decoder, plus an active-low digit enable. Value updates are deferred to frame boundaries to prevent tearing, and optional leading-zero blanking is supported.

Parameters:
NUM_DIGITS, 8, digits scanned; value width = 4*NUM_DIGITS; legal range 2..8.
PRESCALE, 50000, clk cycles per digit slot; must be ≥2; counter width = clog2(PRESCALE).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  single-cycle strobe: capture value.
value  input  4*NUM_DIGITS  data to display; nibble i drives digit i (digit 0 = LSB, rightmost).
blank_lz  input  1  1 = suppress leading zeros.
nibble  output  4  hex digit for the decoder's x input.
digit_an  output  NUM_DIGITS  active-low digit enables; at most one bit low.
seg_blank  output  1  1 = current slot is dark; segments are forced off downstream.
frame_start  output  1  one-cycle pulse when digit 0 is selected.

Behaviour:
- Reset is async on rst rising edge, with no clock needed:
  - prescaler=0, idx=0, disp_reg=0, pend_reg=0, pend_valid=0.
  - nibble=0, digit_an=all 1s, seg_blank=1, frame_start=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle where count==PRESCALE-1.
- Digit index:
  - On tick, idx ← (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - The first tick after reset selects digit 1. Digit 0 appears at the first wrap, not before.
- Capture:
  - load=1 → pend_reg←value, pend_valid←1. Multiple loads within a frame: last wins.
- Commit occurs on a tick where idx wraps to 0:
  - If pend_valid, disp_reg←pend_reg and pend_valid←0.
  - If load is also asserted that cycle, the incoming value is committed directly (bypass) and pend_valid ends 0.
- Outputs are registered and updated only on tick, using the post-update idx and post-commit disp_reg:
  - nibble ← disp_reg[4*idx +: 4].
  - Blanking: slot is blank iff blank_lz=1 AND idx≠0 AND disp_reg[4*NUM_DIGITS-1 : 4*idx]==0. Digit 0 is never blanked.
  - Not blank: digit_an ← ~(1<<idx), seg_blank ← 0.
  - Blank: digit_an ← all 1s, seg_blank ← 1, nibble still driven.
  - frame_start ← 1 when new idx==0, else 0. It is a one-cycle pulse coinciding with the output update.
- Latency:
  - load → new data visible at the next frame start. Worst case ≈ NUM_DIGITS*PRESCALE+1 cycles.
  - Tick → outputs change the following edge, i.e. one register stage.
- blank_lz is sampled at tick only. A mid-slot change takes effect at the next slot.
- rst mid-frame discards pending data immediately. The display goes dark until the scan reaches a slot again.
- All arithmetic is unsigned. Index width = clog2(NUM_DIGITS). No out-of-range slices for legal NUM_DIGITS.

Decomposition:
- Package hex_display_pkg holds:
  - Defaults DEF_NUM_DIGITS=8 and DEF_PRESCALE=50000.
  - Constant DIGIT_OFF (all-ones enable mask).
  - Function clog2 for widths.
- One sub-module, scan_tick_gen: parameterised prescaler producing the single-cycle tick, with async active-high reset.
- The top holds capture/commit registers, idx, blanking logic and output registers.
- hexto7segment is instantiated by the integrator, not inside this block.

Test Plan (sim with PRESCALE=4, NUM_DIGITS=8):
1. Reset release, then load value=0x1234ABCD at cycle 2. Required: digit_an stays all 1s until the first tick. On wrap, frame_start=1, digit_an=0xFE, nibble=0xD. Subsequent slots give C,B,A,4,3,2,1 with digit_an 0xFD…0x7F.
2. Mid-frame update: while slot 3 of value 0x11111111 is displayed, load 0x22222222. Required: slots 4–7 still show 1. From the next frame_start, all slots show 2.
3. Load coincident with wrap tick, pend_valid holding 0x33333333 and load value 0x44444444. Required: digit 0 of the new frame shows 4, and pend_valid=0 afterwards.
4. Leading-zero blanking, blank_lz=1, value=0x000000A0. Required: slot 0 nibble 0 lit. Slot 1 nibble A lit, digit_an=0xFD. Slots 2–7 have seg_blank=1 and digit_an=0xFF. value=0 → only digit 0 lit, showing 0.
5. Async reset mid-slot: assert rst between clock edges during slot 5. Required: outputs immediately return to nibble=0, digit_an=0xFF, seg_blank=1, with no clk edge. Pending data is lost. After release and reload, scanning restarts per scenario 1.
6. Back-to-back loads, three consecutive cycles (0x5, 0x6, 0x7) within one frame. Required: the next frame shows 0x00000007, with blanking off giving slots 7..1 = 0 and slot 0 = 7.
